// File: rtl/vectored_interrupt_controller.sv
// Fixed-priority vectored interrupt controller: edge-latched requests, PC save/redirect, drain stalls.
// Optional VIC_IRQ_SYNC_EN adds a 2-flop synchronizer on each irq bit ahead of edge detection.
module vectored_interrupt_controller #(
    parameter int              NUM_IRQ      = 8,
    parameter int              PC_W         = 12,
    parameter logic [PC_W-1:0] ISR_BASE     = 12'h800,
    parameter logic [PC_W-1:0] VEC_STRIDE   = 12'h010,
    parameter int              STALL_CYCLES = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [PC_W-1:0]    pc,
    input  logic               pc_valid,
    input  logic [6:0]         if_opcode,
    input  logic [11:0]        if_funct12,
    output logic               sel_isr,
    output logic               ret_isr,
    output logic               isr_stall,
    output logic [PC_W-1:0]    isr_pc,
    output logic [PC_W-1:0]    save_pc,
    output logic [3:0]         active_id,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [NUM_IRQ-1:0] pending
);

    localparam int              CNT_W = $clog2(STALL_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STALL_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ENTER, ACTIVE, RETURN} state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   count, count_n;
    logic [NUM_IRQ-1:0] irq_s, irq_q, rise, eligible, grant;
    logic [NUM_IRQ-1:0] pending_n, irq_ack_n;
    logic [PC_W-1:0]    vector, isr_pc_n, save_pc_n;
    logic [3:0]         winner, active_id_n;
    logic               found, uret;
    logic               sel_isr_n, ret_isr_n, isr_stall_n;

`ifdef VIC_IRQ_SYNC_EN
    logic [NUM_IRQ-1:0] sync_1, sync_2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= irq;
            sync_2 <= sync_1;
        end
    end

    assign irq_s = sync_2;
`else
    assign irq_s = irq;
`endif

    // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq_q <= '0;
        else     irq_q <= irq_s;
    end

    assign rise     = irq_s & ~irq_q;
    assign eligible = pending & irq_en;
    assign uret     = (if_opcode == 7'h73) && (if_funct12 == 12'h002);

    // Descending scan so the lowest eligible index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                winner = 4'(i);
                found  = 1'b1;
            end
        end
    end

    assign grant  = found ? (NUM_IRQ'(1) << winner) : '0;
    assign vector = ISR_BASE + PC_W'(winner) * VEC_STRIDE;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_n     = state;
        count_n     = count;
        sel_isr_n   = sel_isr;
        ret_isr_n   = 1'b0;
        isr_stall_n = isr_stall;
        isr_pc_n    = isr_pc;
        save_pc_n   = save_pc;
        active_id_n = active_id;
        irq_ack_n   = '0;
        pending_n   = pending;

        case (state)
            IDLE: begin
                if (found && pc_valid) begin
                    state_n     = ENTER;
                    save_pc_n   = pc;
                    active_id_n = winner;
                    isr_pc_n    = vector;
                    irq_ack_n   = grant;
                    pending_n   = pending & ~grant;
                    sel_isr_n   = 1'b1;
                    isr_stall_n = 1'b1;
                    count_n     = '0;
                end
            end
            ENTER, RETURN: begin
                if (count == LAST) begin
                    isr_stall_n = 1'b0;
                    count_n     = '0;
                    state_n     = (state == ENTER) ? ACTIVE : IDLE;
                end else begin
                    count_n = count + 1'b1;
                end
            end
            ACTIVE: begin
                if (uret) begin
                    sel_isr_n   = 1'b0;
                    ret_isr_n   = 1'b1;
                    isr_stall_n = 1'b1;
                    count_n     = '0;
                    state_n     = RETURN;
                end
            end
            default: state_n = IDLE;
        endcase

        // A new edge re-arms a channel even in the cycle it is being acknowledged.
        pending_n = pending_n | rise;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= '0;
            sel_isr   <= 1'b0;
            ret_isr   <= 1'b0;
            isr_stall <= 1'b0;
            isr_pc    <= '0;
            save_pc   <= '0;
            active_id <= '0;
            irq_ack   <= '0;
            pending   <= '0;
        end else begin
            state     <= state_n;
            count     <= count_n;
            sel_isr   <= sel_isr_n;
            ret_isr   <= ret_isr_n;
            isr_stall <= isr_stall_n;
            isr_pc    <= isr_pc_n;
            save_pc   <= save_pc_n;
            active_id <= active_id_n;
            irq_ack   <= irq_ack_n;
            pending   <= pending_n;
        end
    end

endmodule

// File: tb/tb_vectored_interrupt_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a countdown-based behavioural model.
module tb_vectored_interrupt_controller;

    localparam int NUM   = 8;
    localparam int STALL = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [NUM-1:0]  irq, irq_en, irq_ack, pending;
    logic [11:0]     pc, isr_pc, save_pc, if_funct12;
    logic            pc_valid, sel_isr, ret_isr, isr_stall;
    logic [6:0]      if_opcode;
    logic [3:0]      active_id;

    int checks = 0;
    int errors = 0;

    vectored_interrupt_controller dut (
        .clk        (clk),
        .rst        (rst),
        .irq        (irq),
        .irq_en     (irq_en),
        .pc         (pc),
        .pc_valid   (pc_valid),
        .if_opcode  (if_opcode),
        .if_funct12 (if_funct12),
        .sel_isr    (sel_isr),
        .ret_isr    (ret_isr),
        .isr_stall  (isr_stall),
        .isr_pc     (isr_pc),
        .save_pc    (save_pc),
        .active_id  (active_id),
        .irq_ack    (irq_ack),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: phase plus a remaining-stall countdown.
    bit [NUM-1:0] m_pend, m_prev, m_ack, m_seen, m_rise, m_elig;
    bit           m_sel, m_ret;
    int           m_stall_left, m_phase, m_id;
    bit [11:0]    m_save, m_isr;
`ifdef VIC_IRQ_SYNC_EN
    bit [NUM-1:0] m_s1, m_s2;
`endif

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pend = '0; m_prev = '0; m_ack = '0; m_sel = 0; m_ret = 0;
            m_stall_left = 0; m_phase = 0; m_id = 0; m_save = '0; m_isr = '0;
`ifdef VIC_IRQ_SYNC_EN
            m_s1 = '0; m_s2 = '0;
`endif
        end else begin
`ifdef VIC_IRQ_SYNC_EN
            m_seen = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
            m_seen = irq;
`endif
            m_rise = m_seen & ~m_prev;
            m_prev = m_seen;
            m_ack  = '0;
            m_ret  = 0;
            m_elig = m_pend & irq_en;
            case (m_phase)
                0: if (m_elig != 0 && pc_valid) begin
                    m_ack  = m_elig & (~m_elig + 1'b1);
                    m_id   = $clog2(m_ack);
                    m_isr  = 12'((32'h800 + m_id * 16) % 4096);
                    m_save = pc;
                    m_pend = m_pend & ~m_ack;
                    m_sel  = 1;
                    m_stall_left = STALL;
                    m_phase = 1;
                end
                1, 3: begin
                    m_stall_left--;
                    if (m_stall_left == 0) m_phase = (m_phase == 1) ? 2 : 0;
                end
                2: if (if_opcode == 7'h73 && if_funct12 == 12'h002) begin
                    m_sel = 0;
                    m_ret = 1;
                    m_stall_left = STALL;
                    m_phase = 3;
                end
                default: m_phase = 0;
            endcase
            m_pend = m_pend | m_rise;
        end
    end

    always @(negedge clk) begin
        check("sel_isr",   32'(sel_isr),   32'(m_sel));
        check("ret_isr",   32'(ret_isr),   32'(m_ret));
        check("isr_stall", 32'(isr_stall), 32'(m_stall_left > 0));
        check("isr_pc",    32'(isr_pc),    32'(m_isr));
        check("save_pc",   32'(save_pc),   32'(m_save));
        check("active_id", 32'(active_id), 32'(m_id));
        check("irq_ack",   32'(irq_ack),   32'(m_ack));
        check("pending",   32'(pending),   32'(m_pend));
    end

    task automatic do_return();
        if_opcode = 7'h73; if_funct12 = 12'h002;
        @(negedge clk);
        if_opcode = 7'h00; if_funct12 = 12'h000;
        check("ret_pulse", 32'(ret_isr), 1);
        check("ret_sel_low", 32'(sel_isr), 0);
        repeat (STALL) @(negedge clk);
        check("ret_stall_done", 32'(isr_stall), 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1; irq = '0; irq_en = 8'hFF; pc = '0; pc_valid = 1'b0;
        if_opcode = '0; if_funct12 = '0;
        repeat (2) @(negedge clk);
        check("rst_sel", 32'(sel_isr), 0);
        check("rst_pending", 32'(pending), 0);
        check("rst_isr_pc", 32'(isr_pc), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single request on channel 3.
        pc = 12'h124; pc_valid = 1'b1; irq[3] = 1'b1;
        @(negedge clk);
        irq[3] = 1'b0;
        check("t1_pending", 32'(pending), 32'h08);
        @(negedge clk);
        check("t1_ack", 32'(irq_ack), 32'h08);
        check("t1_save", 32'(save_pc), 32'h124);
        check("t1_isr_pc", 32'(isr_pc), 32'h830);
        check("t1_sel", 32'(sel_isr), 1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!isr_stall) break;
            n++;
            @(negedge clk);
        end
        check("t1_stall_len", 32'(n), STALL);
        if_opcode = 7'h73; if_funct12 = 12'h000;
        repeat (2) @(negedge clk);
        check("t1_ecall_ignored", 32'(ret_isr), 0);
        check("t1_ecall_sel", 32'(sel_isr), 1);
        do_return();

        // Priority and masking: channel 2 masked until after the return.
        irq_en = 8'hFB; irq[5] = 1'b1; irq[2] = 1'b1;
        @(negedge clk);
        irq = '0;
        check("t2_pending", 32'(pending), 32'h24);
        @(negedge clk);
        check("t2_ack", 32'(irq_ack), 32'h20);
        check("t2_isr_pc", 32'(isr_pc), 32'h850);
        repeat (STALL) @(negedge clk);
        do_return();
        check("t2_held", 32'(pending), 32'h04);
        irq_en = 8'hFF;
        @(negedge clk);
        check("t2_ack2", 32'(irq_ack), 32'h04);
        check("t2_isr_pc2", 32'(isr_pc), 32'h820);
        repeat (STALL) @(negedge clk);
        do_return();

        // pc_valid gating.
        pc_valid = 1'b0; irq[1] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            irq[1] = 1'b0;
            check("t3_no_ack", 32'(irq_ack), 0);
        end
        pc = 12'h3A0; pc_valid = 1'b1;
        @(negedge clk);
        check("t3_ack", 32'(irq_ack), 32'h02);
        check("t3_save", 32'(save_pc), 32'h3A0);
        repeat (STALL) @(negedge clk);
        do_return();

        // Arrivals while active are absorbed and served once after return.
        irq[4] = 1'b1;
        @(negedge clk);
        irq[4] = 1'b0;
        repeat (1 + STALL) @(negedge clk);
        irq[0] = 1'b1; @(negedge clk);
        irq[0] = 1'b0; @(negedge clk);
        irq[0] = 1'b1; @(negedge clk);
        irq[0] = 1'b0;
        check("t4_pending", 32'(pending), 32'h01);
        check("t4_no_nest", 32'(active_id), 4);
        do_return();
        @(negedge clk);
        check("t4_ack", 32'(irq_ack), 32'h01);
        check("t4_isr_pc", 32'(isr_pc), 32'h800);
        repeat (STALL) @(negedge clk);
        do_return();
        check("t4_once", 32'(pending), 0);

        // Asynchronous reset with the entry counter at 2.
        irq[7] = 1'b1;
        @(negedge clk);
        irq[7] = 1'b0;
        @(negedge clk);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1; irq[6] = 1'b1;
        #1;
        check("t5_sel", 32'(sel_isr), 0);
        check("t5_stall", 32'(isr_stall), 0);
        check("t5_ret", 32'(ret_isr), 0);
        check("t5_pending", 32'(pending), 0);
        check("t5_save", 32'(save_pc), 0);
        check("t5_isr_pc", 32'(isr_pc), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`ifndef VIC_IRQ_SYNC_EN
        check("t5_level_edge", 32'(pending), 32'h40);
`endif
        irq[6] = 1'b0;
        repeat (12) @(negedge clk);
        if (sel_isr) do_return();

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            irq = irq ^ NUM'($urandom & $urandom & $urandom);
            if (c % 64 == 0) irq_en = NUM'($urandom | $urandom);
            pc = 12'($urandom);
            pc_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r < 3) begin
                if_opcode = 7'h73; if_funct12 = 12'h002;
            end else if (r == 3) begin
                if_opcode = 7'h73; if_funct12 = 12'($urandom_range(0, 1) == 0 ? 0 : $urandom);
            end else begin
                if_opcode = 7'($urandom); if_funct12 = 12'($urandom);
            end
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vectored_interrupt_controller.md
# vectored_interrupt_controller

Parametrised, multi-channel, vectored interrupt controller for the RV32IMC pipeline, sitting beside the PC/fetch stage. It latches edges on NUM_IRQ request lines and arbitrates them by fixed priority. When the front end reports a clean PC, it saves that PC, redirects fetch to a per-channel ISR vector, and stalls the pipeline for a fixed drain window. A URET in fetch restores the saved PC with the same stall window.

## Interface
- NUM_IRQ, 8: number of interrupt channels (1..16); channel 0 is highest priority
- PC_W, 12: PC / address width
- ISR_BASE, 12'h800: vector address of channel 0
- VEC_STRIDE, 12'h010: address distance between consecutive channel vectors
- STALL_CYCLES, 5: pipeline drain cycles on entry and on return (>=1)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- irq  in  NUM_IRQ  interrupt requests; rising edge raises pending
- irq_en  in  NUM_IRQ  per-channel enable; masked pending bits are held, not dropped
- pc  in  PC_W  current IF-stage PC
- pc_valid  in  1  PC is safe to save (no branch correction, misprediction or ID redirect in flight)
- if_opcode  in  7  IF-stage opcode
- if_funct12  in  12  IF-stage instr[31:20]
- sel_isr  out  1  fetch from isr_pc; high from entry until URET accepted
- ret_isr  out  1  one-cycle pulse: fetch from save_pc
- isr_stall  out  1  pipeline stall during entry/return drain
- isr_pc  out  PC_W  vector of the active channel
- save_pc  out  PC_W  PC saved at entry
- active_id  out  4  active channel index
- irq_ack  out  NUM_IRQ  one-hot, one-cycle acknowledge at entry
- pending  out  NUM_IRQ  latched pending bits

## Operation
- Edge detect: irq_q <= irq each cycle; on rise, pending[i] is set. Set wins over a same-cycle clear. A re-edge while already pending is absorbed.
- Eligible = pending & irq_en. Winner is the lowest eligible index.
- FSM states: IDLE, ENTER, ACTIVE, RETURN.
- IDLE -> ENTER: requires an eligible channel and pc_valid=1 at the clock edge. On that edge:
  - save_pc <= pc
  - active_id <= winner
  - pending[winner] <= 0
  - irq_ack[winner] <= 1 for one cycle
  - sel_isr <= 1, isr_stall <= 1, counter <= 0
- If pc_valid=0, the FSM stays in IDLE and all pending bits stay set.
- ENTER: counter increments each cycle. When counter == STALL_CYCLES-1: isr_stall <= 0, state <= ACTIVE.
- ACTIVE: URET is if_opcode==7'h73 with if_funct12==12'h002. On URET: sel_isr <= 0, ret_isr <= 1 for one cycle, isr_stall <= 1, counter <= 0, state <= RETURN.
- Opcode 7'h73 with any other funct12 (ECALL, CSR ops) is ignored.
- No nesting: edges arriving in ENTER, ACTIVE or RETURN only set pending.
- RETURN: counter runs as in ENTER; at STALL_CYCLES-1, isr_stall <= 0 and state <= IDLE.
- URET seen in IDLE, ENTER or RETURN is ignored.
- isr_pc = ISR_BASE + active_id*VEC_STRIDE, truncated to PC_W (wraps modulo 2^PC_W). It is registered alongside active_id.
- save_pc is held until the next entry.

## Timing
- Reset (async, any state, including mid-ENTER/RETURN):
  - all outputs 0
  - state IDLE, pending 0, counter 0
  - irq_q cleared; after reset a level already high on irq produces one edge.
- Edge on irq at edge N: pending visible after N (IRQ_SYNC_EN off). Entry at edge N+1 at the earliest.
- isr_stall is high for exactly STALL_CYCLES cycles per entry and per return.
- Earliest next entry: the edge after RETURN ends (IDLE for at least one cycle).
- Counter width is clog2(STALL_CYCLES)+1 bits; it never wraps.

## Configuration
- VIC_IRQ_SYNC_EN defined: each irq bit passes through a 2-flop synchronizer before edge detect. Pending is set 2 cycles later than without it. Reset clears the synchronizer.
- VIC_IRQ_SYNC_EN undefined: irq goes directly to edge detect; it must be synchronous to clk.

## Test plan
- Single request: pulse irq[3] (defaults), pc=12'h124, pc_valid=1 -> next edge: irq_ack=8'h08, save_pc=12'h124, isr_pc=12'h830, sel_isr=1; isr_stall high 5 cycles.
- Priority and masking: irq[5] and irq[2] rise together with irq_en=8'hFB -> channel 5 served first (isr_pc=12'h850). pending[2] stays 1 until irq_en[2] is set after return; then channel 2 is served.
- Return: in ACTIVE, opcode 7'h73 with funct12 12'h002 -> ret_isr one-cycle pulse, sel_isr=0, 5 stall cycles, then IDLE. Funct12 12'h000 -> no effect.
- pc_valid gating: pending set while pc_valid=0 for 4 cycles -> no ack. Entry on the first edge with pc_valid=1, saving that cycle's pc.
- Arrivals while active: irq[0] rises during ACTIVE and re-rises (absorbed) -> served exactly once, immediately after RETURN completes.
- Reset mid-ENTER (counter=2): assert rst asynchronously -> all outputs 0 at once; no ret_isr pulse; pending cleared.
